// File: rtl/rst_release_sequencer.sv
// Staged reset-release controller: holds all downstream blocks in reset, then
// releases the active-low resets one by one in index order with a programmable gap.
module rst_release_sequencer #(
    parameter int NUM_OUTS = 4,
    parameter int CNT_W    = 8,
    parameter int HOLD_CYC = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                SW_RST_REQ,
    input  logic [CNT_W-1:0]    GAP_CFG,
    output logic [NUM_OUTS-1:0] OUT_RST_N,
    output logic                SEQ_DONE,
    output logic                BUSY,
    output logic                SW_RST_ACK
);

    localparam int IDX_W = (NUM_OUTS > 1) ? $clog2(NUM_OUTS) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_OUTS - 1);

    typedef enum logic [1:0] {
        HOLD,
        RELEASE,
        GAP,
        DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] gap_lat;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_nxt;

    assign idx_nxt = idx + IDX_W'(1);

    // The release of a bit happens on the terminal-count edge of HOLD or GAP,
    // so RELEASE is never occupied between edges; this keeps G=0 back-to-back.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= HOLD;
            cnt        <= '0;
            gap_lat    <= '0;
            idx        <= '0;
            OUT_RST_N  <= '0;
            SEQ_DONE   <= 1'b0;
            BUSY       <= 1'b1;
            SW_RST_ACK <= 1'b0;
        end else begin
            SW_RST_ACK <= 1'b0;
            case (state)
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        OUT_RST_N[0] <= 1'b1;
                        gap_lat      <= GAP_CFG;
                        cnt          <= '0;
                        idx          <= '0;
                        state        <= GAP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                GAP: begin
                    if (cnt == gap_lat) begin
                        OUT_RST_N[idx_nxt] <= 1'b1;
                        idx                <= idx_nxt;
                        cnt                <= '0;
                        if (idx_nxt == LAST_IDX) begin
                            SEQ_DONE <= 1'b1;
                            BUSY     <= 1'b0;
                            state    <= DONE;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (SW_RST_REQ) begin
                        OUT_RST_N  <= '0;
                        SEQ_DONE   <= 1'b0;
                        BUSY       <= 1'b1;
                        SW_RST_ACK <= 1'b1;
                        cnt        <= '0;
                        idx        <= '0;
                        state      <= HOLD;
                    end
                end
                default: begin
                    state <= HOLD;
                    cnt   <= '0;
                    idx   <= '0;
                end
            endcase
        end
    end

endmodule
